// File: rtl/mem_write_checker.sv
// Watches processor data-memory writes during a run and compares them, in order,
// against a preloaded table of expected address/data pairs; reports pass, mismatch or timeout.
module mem_write_checker #(
    parameter int WIDTH          = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IGNORE_ADR     = 80,
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int MC_W  = ($clog2(NUM_CHECKS + 1) > 1) ? $clog2(NUM_CHECKS + 1) : 1,
    localparam int CC_W  = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [WIDTH-1:0] load_adr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [WIDTH-1:0] fail_adr,
    output logic [WIDTH-1:0] fail_data,
    output logic [MC_W-1:0]  match_count,
    output logic [CC_W-1:0]  cycle_count
);

    localparam int TBL_DEPTH = 1 << IDX_W;
    localparam int IDX_W1    = IDX_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ADR     = 2'b01;
    localparam logic [1:0] FC_DATA    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    localparam logic [IDX_W:0]    NUM_IDX  = IDX_W1'(NUM_CHECKS);
    localparam logic [MC_W-1:0]   MC_LAST  = MC_W'(NUM_CHECKS - 1);
    localparam logic [CC_W-1:0]   CC_MAX   = CC_W'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0]  IGNORE_W = WIDTH'(IGNORE_ADR);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [MC_W-1:0]  match_nx;
    logic [CC_W-1:0]  cycle_nx;
    logic [1:0]       code_nx;
    logic [WIDTH-1:0] fadr_nx;
    logic [WIDTH-1:0] fdata_nx;

    logic             load_ok;
    logic             wr_hit;
    logic [IDX_W-1:0] cur_idx;
    logic [WIDTH-1:0] exp_adr;
    logic [WIDTH-1:0] exp_data;

    // Power-up contents are zero; afterwards only IDLE loads change an entry.
    logic [WIDTH-1:0] tbl_adr  [TBL_DEPTH] = '{default: '0};
    logic [WIDTH-1:0] tbl_data [TBL_DEPTH] = '{default: '0};

    assign load_ok  = ({1'b0, load_idx} < NUM_IDX);
    assign wr_hit   = memwrite && (dataadr != IGNORE_W);
    assign cur_idx  = match_count[IDX_W-1:0];
    assign exp_adr  = tbl_adr[cur_idx];
    assign exp_data = tbl_data[cur_idx];

    // NOTE: the table is deliberately left out of reset so it can map onto RAM
    // and so an aborted run can be repeated without reloading.
    always_ff @(posedge clk) begin
        if (!reset && (state == ST_IDLE) && load_en && load_ok) begin
            tbl_adr[load_idx]  <= load_adr;
            tbl_data[load_idx] <= load_data;
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        match_nx = match_count;
        cycle_nx = cycle_count;
        code_nx  = fail_code;
        fadr_nx  = fail_adr;
        fdata_nx = fail_data;

        if (state == ST_RUN) begin
            if (cycle_count != CC_MAX) begin
                cycle_nx = cycle_count + 1'b1;
            end

            // A mismatch outranks a timeout on the same cycle; a final match outranks both.
            if (wr_hit && (dataadr != exp_adr)) begin
                state_nx = ST_FAIL;
                code_nx  = FC_ADR;
                fadr_nx  = dataadr;
                fdata_nx = writedata;
            end else if (wr_hit && (writedata != exp_data)) begin
                state_nx = ST_FAIL;
                code_nx  = FC_DATA;
                fadr_nx  = dataadr;
                fdata_nx = writedata;
            end else begin
                if (wr_hit) begin
                    match_nx = match_count + 1'b1;
                end
                if (wr_hit && (match_count == MC_LAST)) begin
                    state_nx = ST_PASS;
                end else if (cycle_count == CC_MAX) begin
                    state_nx = ST_FAIL;
                    code_nx  = FC_TIMEOUT;
                    fadr_nx  = '0;
                    fdata_nx = '0;
                end
            end
        end else if (start) begin
            state_nx = ST_RUN;
            match_nx = '0;
            cycle_nx = '0;
            code_nx  = FC_NONE;
            fadr_nx  = '0;
            fdata_nx = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= FC_NONE;
            fail_adr    <= '0;
            fail_data   <= '0;
            match_count <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            busy        <= (state_nx == ST_RUN);
            done        <= (state_nx == ST_PASS) || (state_nx == ST_FAIL);
            pass        <= (state_nx == ST_PASS);
            fail        <= (state_nx == ST_FAIL);
            fail_code   <= code_nx;
            fail_adr    <= fadr_nx;
            fail_data   <= fdata_nx;
            match_count <= match_nx;
            cycle_count <= cycle_nx;
        end
    end

    // Status flags are mutually exclusive and done mirrors the two end states.
    a_flags_exclusive: assert property (@(posedge clk) disable iff (reset)
        $onehot0({busy, pass, fail}));
    a_done_consistent: assert property (@(posedge clk) disable iff (reset)
        done == (pass | fail));

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: directed scenarios plus randomized runs
// scored against a run-level reference model of the ordered expected-write table.
module tb_mem_write_checker;

    localparam int W   = 32;
    localparam int NC  = 3;
    localparam int TO  = 16;
    localparam int IGN = 80;

    logic         clk = 1'b0;
    logic         reset, memwrite, load_en, start;
    logic [W-1:0] dataadr, writedata, load_adr, load_data;
    logic [1:0]   load_idx;
    logic         busy, done, pass, fail;
    logic [1:0]   fail_code;
    logic [W-1:0] fail_adr, fail_data;
    logic [1:0]   match_count;
    logic [4:0]   cycle_count;

    int checks = 0;
    int errors = 0;

    // Reference copy of the expected table and the outcome of the last scored run.
    logic [W-1:0] m_adr  [NC] = '{default: '0};
    logic [W-1:0] m_data [NC] = '{default: '0};

    bit           pl_we   [$];
    logic [W-1:0] pl_adr  [$];
    logic [W-1:0] pl_data [$];

    always #5 clk = ~clk;

    mem_write_checker #(
        .WIDTH(W), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO), .IGNORE_ADR(IGN)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .load_en(load_en), .load_idx(load_idx),
        .load_adr(load_adr), .load_data(load_data), .start(start),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_code(fail_code), .fail_adr(fail_adr), .fail_data(fail_data),
        .match_count(match_count), .cycle_count(cycle_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        load_en   = 1'b0;
        load_idx  = '0;
        load_adr  = '0;
        load_data = '0;
        start     = 1'b0;
    endtask

    task automatic plan_clear();
        pl_we.delete();
        pl_adr.delete();
        pl_data.delete();
    endtask

    task automatic plan_add(input bit we, input int a, input int d);
        pl_we.push_back(we);
        pl_adr.push_back(W'(a));
        pl_data.push_back(W'(d));
    endtask

    // Loads one entry while the checker sits in IDLE.
    task automatic load_entry(input int idx, input int a, input int d);
        load_en   = 1'b1;
        load_idx  = 2'(idx);
        load_adr  = W'(a);
        load_data = W'(d);
        tick();
        load_en = 1'b0;
        if (idx < NC) begin
            m_adr[idx]  = W'(a);
            m_data[idx] = W'(d);
        end
    endtask

    // Starts a run, drives either the plan queue or random traffic, and scores
    // every cycle against the ordered-table rules.
    task automatic run_and_score(input bit rnd, input string tag);
        bit           ended  = 1'b0;
        bit           passed = 1'b0;
        int           post   = 0;
        int           k      = 0;
        int           t      = 0;
        int           cc     = 0;
        int           code   = 0;
        logic [W-1:0] fa     = '0;
        logic [W-1:0] fd     = '0;

        start = 1'b1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        checks++;
        if ({busy, done, match_count, cycle_count, fail_code} !== {1'b1, 1'b0, 2'd0, 5'd0, 2'd0}) begin
            errors++;
            $display("FAIL %s run_start busy=%b done=%b match=%0d cycles=%0d code=%0d, want 1 0 0 0 0",
                     tag, busy, done, match_count, cycle_count, fail_code);
        end

        while (post < 3) begin
            bit           we;
            logic [W-1:0] a, d;
            int           r;
            logic [3:0]   want_st;
            we = 1'b0;
            a  = '0;
            d  = '0;
            if (!ended) begin
                if (rnd) begin
                    r = $urandom_range(0, 7);
                    if (r == 3) begin
                        we = 1'b1; a = W'(IGN); d = W'($urandom);
                    end else if (r == 4) begin
                        we = 1'b1; a = W'(84 + 4 * $urandom_range(0, 3)); d = W'($urandom_range(0, 3));
                    end else if (r >= 5) begin
                        we = 1'b1; a = m_adr[k]; d = m_data[k];
                    end
                    start     = ($urandom_range(0, 4) == 0);
                    load_en   = ($urandom_range(0, 3) == 0);
                    load_idx  = 2'($urandom_range(0, 3));
                    load_adr  = W'($urandom);
                    load_data = W'($urandom);
                end else if (t < pl_we.size()) begin
                    we = pl_we[t]; a = pl_adr[t]; d = pl_data[t];
                end
            end else begin
                start     = 1'b0;
                we        = $urandom_range(0, 1) == 1;
                a         = m_adr[$urandom_range(0, NC - 1)];
                d         = W'($urandom);
                load_en   = 1'b1;
                load_idx  = 2'($urandom_range(0, 3));
                load_adr  = W'($urandom);
                load_data = W'($urandom);
            end
            memwrite  = we;
            dataadr   = a;
            writedata = d;

            if (!ended) begin
                if (we && a != W'(IGN)) begin
                    if (a != m_adr[k]) begin
                        ended = 1'b1; code = 1; fa = a; fd = d;
                    end else if (d != m_data[k]) begin
                        ended = 1'b1; code = 2; fa = a; fd = d;
                    end else begin
                        k++;
                        if (k == NC) begin
                            ended = 1'b1; passed = 1'b1;
                        end
                    end
                end
                if (!ended && t == TO) begin
                    ended = 1'b1; code = 3; fa = '0; fd = '0;
                end
                cc = (t + 1 < TO) ? t + 1 : TO;
            end else begin
                post++;
            end

            tick();
            t++;
            want_st = {!ended, ended, ended && passed, ended && !passed};
            checks++;
            if ({busy, done, pass, fail} !== want_st) begin
                errors++;
                $display("FAIL %s status t=%0d busy/done/pass/fail=%b want %b", tag, t - 1,
                         {busy, done, pass, fail}, want_st);
            end
            checks++;
            if (match_count !== 2'(k) || cycle_count !== 5'(cc)) begin
                errors++;
                $display("FAIL %s counts t=%0d match=%0d cycles=%0d want %0d %0d", tag, t - 1,
                         match_count, cycle_count, k, cc);
            end
        end
        idle_inputs();

        checks++;
        if (fail_code !== 2'(code) || fail_adr !== fa || fail_data !== fd) begin
            errors++;
            $display("FAIL %s fail_info code=%0d adr=%0d data=%0d want %0d %0d %0d", tag,
                     fail_code, fail_adr, fail_data, code, fa, fd);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, pass, fail} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, pass, fail});
        end
        checks++;
        if (fail_code !== 2'd0 || match_count !== 2'd0 || cycle_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_counts code=%0d match=%0d cycles=%0d want 0 0 0",
                     fail_code, match_count, cycle_count);
        end
        checks++;
        if (fail_adr !== '0 || fail_data !== '0) begin
            errors++;
            $display("FAIL reset_fail_fields adr=%0d data=%0d want 0 0", fail_adr, fail_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pass_basic();
        load_entry(0, 84, 7);
        load_entry(1, 88, 9);
        load_entry(2, 92, 11);
        load_entry(3, 200, 200);
        plan_clear();
        plan_add(1, 80, 3);
        plan_add(1, 84, 7);
        plan_add(0, 0, 0);
        plan_add(1, 88, 9);
        plan_add(1, 92, 11);
        run_and_score(1'b0, "pass_basic");
        checks++;
        if (pass !== 1'b1 || match_count !== 2'd3 || fail_code !== 2'd0 || cycle_count !== 5'd5) begin
            errors++;
            $display("FAIL pass_basic pass=%b match=%0d code=%0d cycles=%0d want 1 3 0 5",
                     pass, match_count, fail_code, cycle_count);
        end
    endtask

    task automatic test_data_mismatch();
        plan_clear();
        plan_add(1, 84, 6);
        run_and_score(1'b0, "data_mm");
        checks++;
        if (fail !== 1'b1 || fail_code !== 2'b10 || fail_adr !== 32'd84 || fail_data !== 32'd6) begin
            errors++;
            $display("FAIL data_mm fail=%b code=%b adr=%0d data=%0d want 1 10 84 6",
                     fail, fail_code, fail_adr, fail_data);
        end
    endtask

    task automatic test_adr_mismatch();
        plan_clear();
        plan_add(1, 88, 9);
        run_and_score(1'b0, "adr_mm");
        checks++;
        if (fail_code !== 2'b01 || fail_adr !== 32'd88 || match_count !== 2'd0) begin
            errors++;
            $display("FAIL adr_mm code=%b adr=%0d match=%0d want 01 88 0",
                     fail_code, fail_adr, match_count);
        end
    endtask

    task automatic test_timeout();
        plan_clear();
        run_and_score(1'b0, "timeout");
        checks++;
        if (fail_code !== 2'b11 || cycle_count !== 5'd16 || fail_adr !== '0 || fail_data !== '0) begin
            errors++;
            $display("FAIL timeout code=%b cycles=%0d adr=%0d data=%0d want 11 16 0 0",
                     fail_code, cycle_count, fail_adr, fail_data);
        end
    endtask

    task automatic test_timeout_races();
        plan_clear();
        for (int i = 0; i < 14; i++) plan_add(0, 0, 0);
        plan_add(1, 84, 7);
        plan_add(1, 88, 9);
        plan_add(1, 92, 11);
        run_and_score(1'b0, "match_on_timeout");
        checks++;
        if (pass !== 1'b1 || fail !== 1'b0 || cycle_count !== 5'd16) begin
            errors++;
            $display("FAIL match_on_timeout pass=%b fail=%b cycles=%0d want 1 0 16",
                     pass, fail, cycle_count);
        end

        plan_clear();
        for (int i = 0; i < 15; i++) plan_add(0, 0, 0);
        plan_add(1, 84, 7);
        plan_add(1, 88, 1);
        run_and_score(1'b0, "mm_on_timeout");
        checks++;
        if (fail_code !== 2'b10 || fail_adr !== 32'd88 || fail_data !== 32'd1 || match_count !== 2'd1) begin
            errors++;
            $display("FAIL mm_on_timeout code=%b adr=%0d data=%0d match=%0d want 10 88 1 1",
                     fail_code, fail_adr, fail_data, match_count);
        end
    endtask

    task automatic test_start_with_load();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        load_en   = 1'b1;
        load_idx  = 2'd0;
        load_adr  = 32'd100;
        load_data = 32'd5;
        m_adr[0]  = 32'd100;
        m_data[0] = 32'd5;
        plan_clear();
        plan_add(1, 100, 5);
        plan_add(1, 88, 9);
        plan_add(1, 92, 11);
        run_and_score(1'b0, "start_with_load");
        checks++;
        if (pass !== 1'b1 || match_count !== 2'd3) begin
            errors++;
            $display("FAIL start_with_load pass=%b match=%0d want 1 3", pass, match_count);
        end
    endtask

    task automatic test_load_ignored_when_done();
        load_en   = 1'b1;
        load_idx  = 2'd1;
        load_adr  = 32'd500;
        load_data = 32'd500;
        tick();
        load_en = 1'b0;
        checks++;
        if ({busy, done, pass, fail} !== 4'b0110) begin
            errors++;
            $display("FAIL sticky_pass flags=%b want 0110", {busy, done, pass, fail});
        end
        plan_clear();
        plan_add(1, 100, 5);
        plan_add(1, 88, 9);
        plan_add(1, 92, 11);
        run_and_score(1'b0, "load_ignored");
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        tick();
        start     = 1'b0;
        memwrite  = 1'b1;
        dataadr   = 32'd100;
        writedata = 32'd5;
        tick();
        checks++;
        if (busy !== 1'b1 || match_count !== 2'd1) begin
            errors++;
            $display("FAIL mid_run busy=%b match=%0d want 1 1", busy, match_count);
        end
        reset     = 1'b1;
        start     = 1'b1;
        load_en   = 1'b1;
        load_idx  = 2'd0;
        load_adr  = 32'd999;
        load_data = 32'd1;
        tick();
        checks++;
        if ({busy, done, pass, fail, fail_code, match_count, cycle_count} !== '0 ||
            fail_adr !== '0 || fail_data !== '0) begin
            errors++;
            $display("FAIL reset_abort flags=%b code=%0d match=%0d cycles=%0d adr=%0d data=%0d want all 0",
                     {busy, done, pass, fail}, fail_code, match_count, cycle_count, fail_adr, fail_data);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if ({busy, done, pass, fail} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset flags=%b want 0000", {busy, done, pass, fail});
        end
        plan_clear();
        plan_add(1, 100, 5);
        plan_add(1, 88, 9);
        plan_add(1, 92, 11);
        run_and_score(1'b0, "table_retained");
        checks++;
        if (pass !== 1'b1) begin
            errors++;
            $display("FAIL table_retained pass=%b want 1", pass);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    load_entry($urandom_range(0, 3), 84 + 4 * $urandom_range(0, 3), $urandom_range(0, 3));
                end
            end
            run_and_score(1'b1, "random");
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_pass_basic();
        test_data_mismatch();
        test_adr_mismatch();
        test_timeout();
        test_timeout_races();
        test_start_with_load();
        test_load_ignored_when_done();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of address and data buses.
REQ-002 SHALL have parameter NUM_CHECKS, default 4, range 1-16, depth of expected-write table.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, RUN cycles allowed before timeout.
REQ-004 SHALL have parameter IGNORE_ADR, default 80, address whose writes are never compared.
REQ-005 SHALL have ports: clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 memwrite  input  1  processor data-memory write strobe.
REQ-008 dataadr  input  WIDTH  processor data-memory address.
REQ-009 writedata  input  WIDTH  processor data-memory write data.
REQ-010 load_en  input  1  write one expected-table entry this cycle.
REQ-011 load_idx  input  clog2(NUM_CHECKS), min 1  table entry index.
REQ-012 load_adr  input  WIDTH  expected address; load_data  input  WIDTH  expected data.
REQ-013 start  input  1  single-cycle pulse, begin checking run.
REQ-014 busy  output  1  high in RUN; done  output  1  high in PASS or FAIL.
REQ-015 pass  output  1  high in PASS; fail  output  1  high in FAIL.
REQ-016 fail_code  output  2  00 none, 01 address mismatch, 10 data mismatch, 11 timeout.
REQ-017 fail_adr, fail_data  output  WIDTH each  offending write captured at failure.
REQ-018 match_count  output  clog2(NUM_CHECKS+1), min 1  expected writes matched so far.
REQ-019 cycle_count  output  clog2(TIMEOUT_CYCLES+1), min 1  cycles spent in current run.

Function
REQ-020 SHALL implement states IDLE, RUN, PASS, FAIL, encoded internally.
REQ-021 IDLE: load_en writes entry load_idx next edge; load_idx >= NUM_CHECKS ignored.
REQ-022 load_en in RUN, PASS or FAIL SHALL be ignored; table retained.
REQ-023 start in IDLE, PASS or FAIL -> RUN next edge; clears match_count, cycle_count, fail_code, fail_adr, fail_data.
REQ-024 start in RUN SHALL be ignored.
REQ-025 start with load_en same cycle in IDLE: load performed, run begins; loaded entry valid for run.
REQ-026 RUN: cycle_count increments each cycle, saturating at TIMEOUT_CYCLES.
REQ-027 RUN, memwrite low: no comparison.
REQ-028 RUN, memwrite high and dataadr == IGNORE_ADR: write discarded, no state change.
REQ-029 RUN, memwrite high, other address: compare to entry[match_count]; ordered checking only.
REQ-030 address and data equal -> match_count +1; if it reaches NUM_CHECKS -> PASS next edge.
REQ-031 address differs -> FAIL, fail_code 01; address equal, data differs -> FAIL, fail_code 10.
REQ-032 on FAIL entry SHALL capture dataadr into fail_adr and writedata into fail_data.
REQ-033 cycle_count reaching TIMEOUT_CYCLES with no final match -> FAIL, fail_code 11, fail_adr/fail_data 0.
REQ-034 final match and timeout same cycle: PASS wins.
REQ-035 mismatch and timeout same cycle: mismatch code wins.
REQ-036 PASS and FAIL sticky until start or reset; inputs other than start, reset ignored.
REQ-037 outputs SHALL be registered; state change visible one cycle after triggering edge.
REQ-038 all comparisons full WIDTH, unsigned, exact equality.

Reset
REQ-039 reset high at edge -> IDLE; busy, done, pass, fail 0; fail_code 00; counts, fail_adr, fail_data 0.
REQ-040 reset mid-RUN SHALL abort run without flagging failure; reset dominates start and load_en.
REQ-041 expected table contents NOT cleared by reset; entries read 0 only after power-up init.

Verification
REQ-042 load {84,7} at idx 0, NUM_CHECKS=1, start; write adr 80 data 3, then adr 84 data 7 -> pass=1, match_count=1, fail_code 00.
REQ-043 same table; write adr 84 data 6 -> fail=1, fail_code 10, fail_adr 84, fail_data 6.
REQ-044 NUM_CHECKS=2 table {84,7},{88,9}; write 88 first -> fail_code 01, fail_adr 88, match_count 0.
REQ-045 TIMEOUT_CYCLES=16, no writes after start -> fail_code 11 when cycle_count=16, busy drops next cycle.
REQ-046 final matching write on timeout cycle -> pass=1, fail=0; reset asserted mid-run -> all outputs 0, table still holds loaded values on next run.
